// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the unified-RAM arbiter.
// Owner encoding is fixed so the owner register can be probed and decoded directly.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_AUX  = 2'b10
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, auxiliary-burst and RAM signals around the arbiter.
// master = requesters plus RAM model side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              aux_req;
  logic [ADDR_W-1:0] aux_base;
  logic [LEN_W-1:0]  aux_len;
  logic              aux_valid;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output aux_req, aux_base, aux_len,
    input  aux_valid, aux_rdata, aux_done,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  aux_req, aux_base, aux_len,
    output aux_valid, aux_rdata, aux_done,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_burst_addr_gen.sv
// Burst address generator: holds the read pointer and beat count of one aux burst.
// o_last pulses for one cycle after the final beat has been granted (done flag).
module burst_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_active,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_active;
  logic              r_done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_active    <= 1'b0;
      r_done_q    <= 1'b0;
    end else begin
      r_done_q <= 1'b0;
      if (i_load) begin
        r_ptr       <= i_base;
        r_remaining <= i_len;
        r_active    <= 1'b1;
      end else if (i_advance && r_active) begin
        r_ptr <= r_ptr + ADDR_W'(1);
        if (r_remaining == '0) begin
          r_active <= 1'b0;
          r_done_q <= 1'b1;
        end else begin
          r_remaining <= r_remaining - LEN_W'(1);
        end
      end
    end
  end

  assign o_addr   = r_ptr;
  assign o_active = r_active;
  assign o_last   = r_done_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the multicycle CPU and a read-only burst master.
// Strict alternation under contention; acks/valids are registered copies of the owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  owner_t            r_owner;
  logic              r_last_aux;
  logic [ADDR_W-1:0] r_aux_addr;
  logic              r_cpu_ack;
  logic              r_cpu_rd;
  logic              r_aux_valid;
  logic              r_aux_done;
  logic [DATA_W-1:0] r_cpu_hold;

  logic [ADDR_W-1:0] w_ptr;
  logic              w_active;
  logic              w_done_q;
  logic              w_load;
  logic              w_cpu_elig;
  logic              w_aux_elig;
  logic              w_grant_cpu;
  logic              w_grant_aux;

  // Capture is also blocked while the done flag is in flight, so a held
  // aux_req cannot restart the burst it has just completed.
  assign w_load      = bus.aux_req & ~w_active & ~w_done_q & ~r_aux_done;
  assign w_cpu_elig  = bus.cpu_req & (r_owner != OWN_CPU) & ~r_cpu_ack;
  assign w_aux_elig  = w_active;
  assign w_grant_cpu = w_cpu_elig & (~w_aux_elig | r_last_aux);
  assign w_grant_aux = w_aux_elig & (~w_cpu_elig | ~r_last_aux);

  burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_advance (w_grant_aux),
    .i_base    (bus.aux_base),
    .i_len     (bus.aux_len),
    .o_addr    (w_ptr),
    .o_active  (w_active),
    .o_last    (w_done_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner     <= OWN_IDLE;
      r_last_aux  <= 1'b1;
      r_aux_addr  <= '0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rd    <= 1'b0;
      r_aux_valid <= 1'b0;
      r_aux_done  <= 1'b0;
      r_cpu_hold  <= '0;
    end else begin
      r_cpu_ack   <= (r_owner == OWN_CPU);
      r_cpu_rd    <= (r_owner == OWN_CPU) & ~bus.cpu_we;
      r_aux_valid <= (r_owner == OWN_AUX);
      r_aux_done  <= w_done_q;
      if (r_cpu_ack && r_cpu_rd) r_cpu_hold <= bus.mem_rdata;

      if (w_grant_cpu) begin
        r_owner    <= OWN_CPU;
        r_last_aux <= 1'b0;
      end else if (w_grant_aux) begin
        r_owner    <= OWN_AUX;
        r_last_aux <= 1'b1;
        r_aux_addr <= w_ptr;
      end else begin
        r_owner <= OWN_IDLE;
      end
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (r_owner)
      OWN_CPU: begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_we    = bus.cpu_we & reset;
        bus.mem_wdata = bus.cpu_wdata;
      end
      OWN_AUX: bus.mem_addr = r_aux_addr;
      default: ;
    endcase
  end

  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_rdata = (r_cpu_ack && r_cpu_rd) ? bus.mem_rdata : r_cpu_hold;
  assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack;
  assign bus.aux_valid = r_aux_valid;
  assign bus.aux_rdata = bus.mem_rdata;
  assign bus.aux_done  = r_aux_done;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single port of the unified instruction/data block RAM and shares it between two requesters.
- The multicycle CPU (controller/datapath) issues single-word reads and writes.
- An auxiliary read-only master (VGA/line fetch, debug) issues sequential read bursts.
- The arbiter sequences grants, generates burst addresses, returns acks and data, and drives the CPU stall.

Parameters:
ADDR_W, 16, memory word-address width
DATA_W, 16, memory data width
LEN_W, 4, burst length field width; burst = aux_len+1 words

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle access-complete pulse
cpu_rdata  out  DATA_W  read data; valid in the ack cycle, held afterwards
cpu_stall  out  1  cpu_req & ~cpu_ack; freezes controller state advance
aux_req  in  1  burst request, held until aux_done
aux_base  in  ADDR_W  burst start address; sampled at burst capture
aux_len  in  LEN_W  burst length minus one; sampled at burst capture
aux_valid  out  1  one pulse per returned word
aux_rdata  out  DATA_W  burst word; valid with aux_valid
aux_done  out  1  asserted with the final aux_valid
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data; synchronous, one cycle after address

Behaviour:
- Reset, on any edge with reset low:
  - owner=IDLE; burst idle; remaining=0; ptr=0; last_winner=AUX.
  - All ack/valid/done outputs 0; cpu_rdata hold register 0.
  - mem_we is forced to 0 whenever reset is low, including the reset cycle.
  - A mid-operation reset aborts any access or burst; no ack or done is ever emitted for it.
- Owner register {IDLE, CPU, AUX} names the master using the RAM in the current cycle.
  - IDLE: mem_addr=0, mem_we=0.
  - CPU: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - AUX: mem_addr=ptr, mem_we=0.
- Ack timing:
  - cpu_ack and aux_valid are registered copies of owner==CPU and owner==AUX, so each pulses the cycle after the grant.
  - Data in that cycle = mem_rdata, passed through combinationally.
  - cpu_rdata keeps the last CPU read value outside ack cycles. Writes also ack, and do not update the hold register.
  - CPU latency: cpu_req high in cycle N gives grant in N+1 and ack in N+2, when uncontended.
- CPU eligibility: cpu_elig = cpu_req & owner!=CPU & ~cpu_ack. This masking prevents duplicate grants while req is still high.
- Burst capture:
  - Condition: aux_req & burst idle & ~aux_done.
  - Action: latch ptr=aux_base and remaining=aux_len; the burst becomes active next cycle.
- Aux eligibility: aux_elig = burst active.
  - Each aux grant advances ptr, wrapping modulo 2^ADDR_W.
  - Each aux grant decrements remaining. Granting the beat with remaining=0 returns the burst to idle and sets done_q.
  - aux_done = registered done_q, coincident with the last aux_valid.
- Arbitration, at each clock edge:
  - Only one eligible: grant it.
  - Both eligible: grant the opposite of last_winner (strict alternation).
  - Neither eligible: owner=IDLE.
  - last_winner updates on every grant.
- Guarantees: back-to-back aux beats when the CPU is idle, and no starvation of either master.
- Simultaneous events: capture and a CPU grant may occur on the same edge. A new aux_req during an active burst is ignored until the burst completes and the done cycle passes.

Decomposition:
- Shared package mem_arb_pkg holds:
  - owner encoding OWN_IDLE=2'b00, OWN_CPU=2'b01, OWN_AUX=2'b10;
  - default ADDR_W/DATA_W/LEN_W.
- One sub-module, burst_addr_gen:
  - contains ptr, remaining, active and done_q;
  - inputs: load, advance, base, len;
  - outputs: addr, active, last.

Test Plan:
- CPU read, no contention: RAM[0x0010]=0xBEEF; cpu_req in cycle 0 -> mem_addr=0x0010 in cycle 1; cpu_ack=1 and cpu_rdata=0xBEEF in cycle 2; cpu_rdata still 0xBEEF in cycle 5.
- CPU write: write 0x1234 to 0x0020 -> mem_we high exactly in cycle 1; read-back of 0x0020 returns 0x1234; no duplicate grant in cycle 2.
- Solo burst: aux_base=0x0100, aux_len=3, aux_req in cycle 0 -> mem_addr 0x0100..0x0103 in cycles 2-5; aux_valid in cycles 3-6; aux_done only in cycle 6; aux_req held through cycle 6 starts no new burst.
- Contention: burst captured at the end of cycle 0 (base 0x0200, len 1); cpu read 0x0010 requested in cycle 1 -> owner CPU in cycle 2, AUX 0x0200 in cycle 3, AUX 0x0201 in cycle 4; cpu_ack in cycle 3; aux_done in cycle 5.
- Wrap: aux_base=0xFFFF, aux_len=1 -> addresses 0xFFFF then 0x0000.
- Reset mid-burst: reset low in cycle 3 of a len=7 burst -> from the next cycle owner=IDLE and aux_valid/aux_done/cpu_ack stay 0; mem_we=0 throughout; a fresh burst after reset starts at its new aux_base.
